// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the instruction-refill, data-cache and memory-port signals that meet at the arbiter.
// The arbiter takes the master modport; the cache/memory side takes the slave modport.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   inst_addr;
  logic                    inst_re;
  logic [DATA_WIDTH-1:0]   inst_rdata;
  logic                    inst_busy;

  logic [ADDR_WIDTH-1:0]   data_addr;
  logic                    data_re;
  logic                    data_we;
  logic [DATA_WIDTH/8-1:0] data_be;
  logic [DATA_WIDTH-1:0]   data_wdata;
  logic [DATA_WIDTH-1:0]   data_rdata;
  logic                    data_busy;

  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_re;
  logic                    mem_we;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_busy;

  logic [1:0]              grant;

  modport master (
    input  inst_addr, inst_re,
    input  data_addr, data_re, data_we, data_be, data_wdata,
    input  mem_rdata, mem_busy,
    output inst_rdata, inst_busy,
    output data_rdata, data_busy,
    output mem_addr, mem_re, mem_we, mem_be, mem_wdata,
    output grant
  );

  modport slave (
    output inst_addr, inst_re,
    output data_addr, data_re, data_we, data_be, data_wdata,
    output mem_rdata, mem_busy,
    input  inst_rdata, inst_busy,
    input  data_rdata, data_busy,
    input  mem_addr, mem_re, mem_we, mem_be, mem_wdata,
    input  grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-way round-robin arbiter sharing the single memory port between the instruction
// refill bus and the data cache bus; a grant is held for as long as its owner requests.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit INST_FIRST = 1'b0
) (
  input logic              i_clock,
  input logic              i_reset,
  mem_bus_arbiter_if.master bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // State encoding doubles as the one-hot {data,inst} grant vector.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GNT_I = 2'b01;
  localparam logic [1:0] GNT_D = 2'b10;

  localparam logic SIDE_INST = 1'b0;
  localparam logic SIDE_DATA = 1'b1;
  localparam logic LAST_RESET = INST_FIRST ? SIDE_DATA : SIDE_INST;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_served;
  logic       last_served_next;
  logic       inst_req;
  logic       data_req;

  assign inst_req = bus.inst_re;
  assign data_req = bus.data_re | bus.data_we;

  always_comb begin
    state_next       = state;
    last_served_next = last_served;
    case (state)
      IDLE: begin
        if (inst_req && data_req) begin
          state_next = (last_served == SIDE_INST) ? GNT_D : GNT_I;
        end else if (inst_req) begin
          state_next = GNT_I;
        end else if (data_req) begin
          state_next = GNT_D;
        end
        if (state_next == GNT_I) begin
          last_served_next = SIDE_INST;
        end else if (state_next == GNT_D) begin
          last_served_next = SIDE_DATA;
        end
      end
      // A dropped request only releases the port once memory is no longer busy.
      GNT_I: begin
        if (!inst_req && !bus.mem_busy) begin
          state_next = IDLE;
        end
      end
      GNT_D: begin
        if (!data_req && !bus.mem_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state       <= IDLE;
      last_served <= LAST_RESET;
    end else begin
      state       <= state_next;
      last_served <= last_served_next;
    end
  end

  // Instruction refills are whole-word reads, so all byte lanes are enabled.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    case (state)
      GNT_I: begin
        bus.mem_addr = bus.inst_addr;
        bus.mem_re   = bus.inst_re;
        bus.mem_be   = {BE_WIDTH{1'b1}};
      end
      GNT_D: begin
        bus.mem_addr  = bus.data_addr;
        bus.mem_re    = bus.data_re;
        bus.mem_we    = bus.data_we;
        bus.mem_be    = bus.data_be;
        bus.mem_wdata = bus.data_wdata;
      end
      default: ;
    endcase
  end

  assign bus.inst_busy  = inst_req & ~((state == GNT_I) & ~bus.mem_busy);
  assign bus.data_busy  = data_req & ~((state == GNT_D) & ~bus.mem_busy);
  assign bus.inst_rdata = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;
  assign bus.grant      = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter, checked every cycle against a
// behavioural owner/priority model of the arbitration rules.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Model: owner 0 = nobody, 1 = instruction side, 2 = data side; last = side served last.
  int   m_owner;
  int   m_last;

  logic [1:0] exp_q[$];

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INST_FIRST(1'b0)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic ireq;
    logic dreq;
    logic own_req;
    ireq = bus.inst_re;
    dreq = bus.data_re | bus.data_we;
    if (!rst) begin
      m_owner = 0;
      m_last  = 1;
    end else if (m_owner == 0) begin
      if (ireq && dreq) m_owner = (m_last == 1) ? 2 : 1;
      else if (ireq)    m_owner = 1;
      else if (dreq)    m_owner = 2;
      if (m_owner != 0) m_last = m_owner;
    end else begin
      own_req = (m_owner == 1) ? ireq : dreq;
      if (!own_req && !bus.mem_busy) m_owner = 0;
    end
  endtask

  task automatic sample();
    logic [1:0]    e_grant;
    logic          e_re;
    logic          e_we;
    logic [BW-1:0] e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          ireq;
    logic          dreq;
    @(negedge clk);
    ireq    = bus.inst_re;
    dreq    = bus.data_re | bus.data_we;
    e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    e_re = 1'b0; e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
    if (m_owner == 1) begin
      e_re = bus.inst_re; e_be = '1; e_addr = bus.inst_addr;
    end else if (m_owner == 2) begin
      e_re = bus.data_re; e_we = bus.data_we; e_be = bus.data_be;
      e_addr = bus.data_addr; e_wdata = bus.data_wdata;
    end
    chk("grant", bus.grant, e_grant);
    chk("mem_re", bus.mem_re, e_re);
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_be", bus.mem_be, e_be);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("inst_busy", bus.inst_busy, ireq && !(m_owner == 1 && !bus.mem_busy));
    chk("data_busy", bus.data_busy, dreq && !(m_owner == 2 && !bus.mem_busy));
    chk("inst_rdata", bus.inst_rdata, bus.mem_rdata);
    chk("data_rdata", bus.data_rdata, bus.mem_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drop_all();
    bus.inst_re = 1'b0;
    bus.data_re = 1'b0;
    bus.data_we = 1'b0;
    bus.mem_busy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [1:0] g;
    g = 2'b11;
    for (int k = 0; k < 16; k++) begin
      sample();
      g = bus.grant;
      tick();
      if (g == 2'b00) break;
    end
    chk(tag, g, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int comp;
    logic [1:0] g;
    int i_left, d_left;
    logic i_on, d_on;
    n_tests = 0;
    n_fail  = 0;
    m_owner = 0;
    m_last  = 1;
    rst = 1'b0;
    bus.inst_addr = '0; bus.data_addr = '0; bus.data_be = '0; bus.data_wdata = '0;
    bus.mem_rdata = '0;
    drop_all();
    do_reset();

    // Reset state
    sample();
    chk("reset_grant", bus.grant, 2'b00);
    chk("reset_re", bus.mem_re, 1'b0);
    tick();

    // 1: instruction refill of 4 words, 2 busy cycles per word
    bus.inst_re = 1'b1; bus.inst_addr = 32'h40; bus.mem_busy = 1'b1;
    sample();
    chk("t1_idle_cycle", bus.grant, 2'b00);
    chk("t1_idle_ibusy", bus.inst_busy, 1'b1);
    tick();
    comp = 0;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 3; b++) begin
        bus.inst_addr = 32'h40 + w * 4;
        bus.mem_busy  = (b < 2);
        bus.mem_rdata = $urandom;
        sample();
        chk("t1_grant", bus.grant, 2'b01);
        chk("t1_re", bus.mem_re, 1'b1);
        chk("t1_dbusy", bus.data_busy, 1'b0);
        if (bus.mem_re && !bus.mem_busy) comp++;
        tick();
      end
    end
    bus.inst_re = 1'b0; bus.mem_busy = 1'b0;
    sample();
    chk("t1_tail_re", bus.mem_re, 1'b0);
    tick();
    sample();
    chk("t1_back_idle", bus.grant, 2'b00);
    tick();
    chk("t1_completions", comp, 4);

    // 2: simultaneous requests right after reset -> data first
    do_reset();
    bus.inst_re = 1'b1; bus.data_re = 1'b1; bus.data_addr = 32'h200;
    sample();
    chk("t2_idle", bus.grant, 2'b00);
    tick();
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("t2_gnt_d", bus.grant, 2'b10);
      chk("t2_ibusy", bus.inst_busy, 1'b1);
      tick();
    end
    bus.data_re = 1'b0;
    sample();
    chk("t2_hold_d", bus.grant, 2'b10);
    tick();
    sample();
    chk("t2_gap_idle", bus.grant, 2'b00);
    chk("t2_gap_ibusy", bus.inst_busy, 1'b1);
    tick();
    sample();
    chk("t2_gnt_i", bus.grant, 2'b01);
    chk("t2_ibusy_clear", bus.inst_busy, 1'b0);
    tick();
    drop_all();
    wait_idle("t2_release");

    // 3: repeated contention alternates D,I,D,I
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    for (int r = 0; r < 4; r++) begin
      bus.inst_re = 1'b1; bus.data_re = 1'b1;
      g = 2'b00;
      for (int k = 0; k < 4; k++) begin
        sample();
        g = bus.grant;
        tick();
        if (g != 2'b00) break;
      end
      chk("t3_order", g, exp_q.pop_front());
      drop_all();
      wait_idle("t3_release");
    end

    // 4: single-cycle data write
    bus.data_we = 1'b1; bus.data_addr = 32'h100; bus.data_wdata = 32'hDEADBEEF;
    bus.data_be = 4'b0011; bus.mem_busy = 1'b0;
    sample();
    tick();
    sample();
    chk("t4_grant", bus.grant, 2'b10);
    chk("t4_we", bus.mem_we, 1'b1);
    chk("t4_re", bus.mem_re, 1'b0);
    chk("t4_addr", bus.mem_addr, 32'h100);
    chk("t4_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("t4_be", bus.mem_be, 4'b0011);
    chk("t4_dbusy", bus.data_busy, 1'b0);
    tick();
    bus.data_we = 1'b0;
    sample();
    chk("t4_we_once", bus.mem_we, 1'b0);
    tick();
    wait_idle("t4_release");

    // 5: reset in the middle of an instruction burst
    bus.inst_re = 1'b1; bus.inst_addr = 32'h80; bus.mem_busy = 1'b1;
    sample();
    tick();
    sample();
    chk("t5_gnt_i", bus.grant, 2'b01);
    tick();
    rst = 1'b0;
    sample();
    chk("t5_sync_reset", bus.grant, 2'b01);
    tick();
    sample();
    chk("t5_grant_cleared", bus.grant, 2'b00);
    chk("t5_re_cleared", bus.mem_re, 1'b0);
    tick();
    rst = 1'b1;
    drop_all();
    wait_idle("t5_idle");
    // Serve data last, then reset: priority must fall back so data wins again.
    bus.data_re = 1'b1;
    sample();
    tick();
    sample();
    chk("t5_data_only", bus.grant, 2'b10);
    tick();
    drop_all();
    wait_idle("t5_idle2");
    do_reset();
    bus.inst_re = 1'b1; bus.data_re = 1'b1;
    sample();
    tick();
    sample();
    chk("t5_prio_reset", bus.grant, 2'b10);
    tick();
    drop_all();
    wait_idle("t5_idle3");

    // 6: request dropped while memory still busy
    bus.data_re = 1'b1; bus.mem_busy = 1'b1;
    sample();
    tick();
    sample();
    chk("t6_gnt_d", bus.grant, 2'b10);
    tick();
    bus.data_re = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t6_hold", bus.grant, 2'b10);
      chk("t6_no_re", bus.mem_re, 1'b0);
      chk("t6_no_we", bus.mem_we, 1'b0);
      tick();
    end
    bus.mem_busy = 1'b0;
    sample();
    chk("t6_last_hold", bus.grant, 2'b10);
    tick();
    sample();
    chk("t6_idle", bus.grant, 2'b00);
    chk("t6_idle_re", bus.mem_re, 1'b0);
    tick();

    // Randomized traffic against the model
    i_on = 1'b0; d_on = 1'b0; i_left = 0; d_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (i_left == 0) begin
        i_on = ~i_on;
        i_left = i_on ? $urandom_range(1, 8) : $urandom_range(0, 4);
      end else begin
        i_left--;
      end
      if (d_left == 0) begin
        d_on = ~d_on;
        d_left = d_on ? $urandom_range(1, 8) : $urandom_range(0, 4);
        case ($urandom_range(0, 3))
          0, 1: begin bus.data_re = d_on; bus.data_we = 1'b0; end
          2:    begin bus.data_re = 1'b0; bus.data_we = d_on; end
          default: begin bus.data_re = d_on; bus.data_we = d_on; end
        endcase
      end else begin
        d_left--;
      end
      bus.inst_re    = i_on;
      bus.inst_addr  = $urandom;
      bus.data_addr  = $urandom;
      bus.data_wdata = $urandom;
      bus.data_be    = BW'($urandom_range(0, 15));
      bus.mem_rdata  = $urandom;
      bus.mem_busy   = ($urandom_range(0, 2) == 0);
      rst            = ($urandom_range(0, 149) != 0);
      sample();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
